prll_bs_rbtr_n_drvrs: RTL and testbench
=======================================

# prll_bs_rbtr_n_drvrs

Parametrised N-driver parallel-bus arbiter and router. It is the successor to the fixed 2-driver bus generator/arbiter wrapper, and sits between driver-side FIFOs on one shared parallel bus. Each transaction follows the same sequence:
- Select one pending driver round-robin and pop its head packet.
- Decode an 8-bit destination ID from the packet MSBs.
- Push the packet to one driver, or to all other drivers on broadcast.
- Honour per-driver `full` backpressure.

## Interface
Parameters:
- `bits`, default 32: packet width; must be > 8.
- `drvrs`, default 4: number of drivers, 1..255.
- `broadcast`, default 8'hFF: destination ID that means "all drivers except source".

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pndng` in `drvrs`: bit i high means driver i FIFO is non-empty and its head is valid on `D_pop` slice i (first-word-fall-through).
- `full` in `drvrs`: bit i high means driver i receive FIFO cannot accept a push.
- `D_pop` in `drvrs*bits`: head packets; slice i is `[i*bits +: bits]`.
- `pop` out `drvrs`: one-cycle pop strobe per driver, registered.
- `push` out `drvrs`: push strobes, registered; may be multi-hot.
- `D_push` out `drvrs*bits`: delivered packet per slice, registered.
- `busy` out 1: high while a transaction is in flight (state != IDLE).
- `drop_cnt` out 16: count of packets dropped for invalid destination; saturating.

## Operation
- Destination field: `dst = pkt[bits-1 -: 8]`.
- State IDLE:
  - If `|pndng`: grant `g` = first set bit searching `ptr, ptr+1, … , drvrs-1, 0, …` (modulo `drvrs`).
  - Latch `g`, set `pop[g]<=1`, go to POP.
  - Otherwise stay in IDLE.
- State POP:
  - `pop<=0`, `pkt <= D_pop slice g`, go to ROUTE.
- State ROUTE: build target `mask` from `dst`:
  - `dst==broadcast`: all ones except bit `g`.
  - `dst<drvrs`: one-hot(`dst`). Self-destination (`dst==g`) is permitted.
  - Otherwise invalid: `drop_cnt<=drop_cnt+1` (saturates at 16'hFFFF), `ptr<=(g+1)%drvrs`, go to IDLE, no push.
  - Valid `mask` with `(mask & full)!=0`: stall in ROUTE. Re-evaluate `full` every cycle with no timeout; `pkt` is held.
  - Otherwise `push<=mask`, every `D_push` slice `<=pkt`, `ptr<=(g+1)%drvrs`, go to IDLE.
  - `mask==0` (broadcast with `drvrs==1`): no push, no drop count, go to IDLE.
- `push` and `pop` are single-cycle pulses. They default to 0 on every edge unless set as above.
- `D_push` holds the last delivered packet until the next delivery. Consumers sample only the slices whose `push` bit is high.
- `pndng` is sampled only in IDLE. Changes to `pndng` in POP/ROUTE are ignored.
- Reset values: state IDLE, `ptr=0`, `g=0`, `pkt=0`, `pop=0`, `push=0`, `D_push=0`, `busy=0`, `drop_cnt=0`.
- Reset mid-transaction discards the in-flight packet (it was already popped) and issues no push. The source FIFO is not restored.

## Timing
- `pndng` sampled high in IDLE at cycle t gives:
  - `pop[g]` high during t+1;
  - `pkt` latched at the end of t+1;
  - ROUTE during t+2;
  - `push` high during t+3 if no stall.
- Each stall cycle adds one cycle. `push` rises in the cycle after the first ROUTE cycle that sees the relevant `full` bits low.
- The IDLE cycle coinciding with `push` may grant again, so the next `pop` can occur at t+4.
- Peak throughput: 1 packet per 3 cycles. Pop-to-push minimum latency is 2 cycles.
- `busy` is high during t+1 .. t+2 (+ stalls), and low in the cycle `push` is high.
- Invalid destination: IDLE at t+3, `drop_cnt` updated visible in t+3.
- Fairness: a continuously pending driver is granted within `drvrs` transactions.

## Test plan
Bench configuration: `drvrs=4`, `bits=32`, `broadcast=8'hFF`.

1. Reset held 2 cycles with all inputs active -> `pop=0`, `push=0`, `D_push=0`, `drop_cnt=0`, `busy=0` throughout and 1 cycle after release.
2. Unicast: `pndng=4'b0001`, `D_pop` slice0=32'h020000AB -> `pop=4'b0001` at t+1; `push=4'b0100` at t+3; `D_push` slice2=32'h020000AB.
3. Broadcast: `pndng=4'b0010`, slice1=32'hFF0000CD -> `push=4'b1101` at t+3; slices 0, 2, 3 = 32'hFF0000CD.
4. Round-robin: `pndng=4'b1111` held, each packet unicast to driver 0 -> pop order 0,1,2,3,0 with pops 3 cycles apart; ptr wraps 3->0.
5. Backpressure: unicast to driver 2 with `full[2]=1` for cycles t+2..t+6 -> `busy` high and `push=0` through t+6; `full[2]` low at t+7 gives `push=4'b0100` at t+8, packet intact.
6. Invalid destination and reset: slice3=32'h07000001 -> no push, `drop_cnt=1` at t+3, next grant starts at driver 0. Then assert `reset` during ROUTE of a valid packet -> no push, all outputs 0, `drop_cnt=0`.

Source files
------------

// File: rtl/prll_bs_rbtr_n_drvrs.sv
// prll_bs_rbtr_n_drvrs: N-driver parallel-bus arbiter and router.
// Grants one pending driver round-robin, pops its head packet, decodes the
// 8-bit destination in the packet MSBs and pushes the packet to one driver or,
// on broadcast, to every driver except the source. A destination whose receive
// FIFO is full stalls the transfer. Invalid destinations are dropped and counted.
module prll_bs_rbtr_n_drvrs #(
  parameter int         bits      = 32,
  parameter int         drvrs     = 4,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [drvrs-1:0]        pndng,
  input  logic [drvrs-1:0]        full,
  input  logic [drvrs*bits-1:0]   D_pop,
  output logic [drvrs-1:0]        pop,
  output logic [drvrs-1:0]        push,
  output logic [drvrs*bits-1:0]   D_push,
  output logic                    busy,
  output logic [15:0]             drop_cnt
);

  // Driver count widened so it can be compared against 8-bit IDs without overflow.
  localparam logic [8:0] num_drv = 9'(drvrs);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    ROUTE = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [7:0]              ptr_r, ptr_s;
  logic [7:0]              g_r, g_s;
  logic [bits-1:0]         pkt_r, pkt_s;
  logic [drvrs-1:0]        pop_r, pop_s;
  logic [drvrs-1:0]        push_r, push_s;
  logic [drvrs*bits-1:0]   d_push_r, d_push_s;
  logic [15:0]             drop_r, drop_s;
  logic                    busy_r;

  logic                    hi_found_s;
  logic [7:0]              hi_g_s;
  logic [7:0]              lo_g_s;
  logic                    found_s;
  logic [7:0]              grant_s;
  logic [bits-1:0]         head_s;
  logic [7:0]              dst_s;
  logic                    is_bcast_s;
  logic                    in_range_s;
  logic [drvrs-1:0]        mask_s;
  logic [7:0]              next_ptr_s;

  // Round-robin search: lowest pending index at or above ptr, else lowest pending overall.
  always_comb begin
    hi_found_s = 1'b0;
    hi_g_s     = 8'd0;
    lo_g_s     = 8'd0;
    for (int i = drvrs - 1; i >= 0; i--) begin
      if (pndng[i]) begin
        lo_g_s = 8'(i);
        if (8'(i) >= ptr_r) begin
          hi_found_s = 1'b1;
          hi_g_s     = 8'(i);
        end else begin
          hi_found_s = hi_found_s;
          hi_g_s     = hi_g_s;
        end
      end else begin
        lo_g_s = lo_g_s;
      end
    end
    found_s = |pndng;
    if (hi_found_s) begin
      grant_s = hi_g_s;
    end else begin
      grant_s = lo_g_s;
    end
  end

  // Head packet of the granted driver, selected with constant slices.
  always_comb begin
    head_s = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (g_r == 8'(i)) begin
        head_s = D_pop[i*bits +: bits];
      end else begin
        head_s = head_s;
      end
    end
  end

  // Destination decode into a target mask; broadcast excludes the source driver.
  always_comb begin
    dst_s      = pkt_r[bits-1 -: 8];
    is_bcast_s = (dst_s == broadcast);
    in_range_s = ({1'b0, dst_s} < num_drv);
    mask_s     = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (is_bcast_s) begin
        mask_s[i] = (g_r != 8'(i));
      end else begin
        mask_s[i] = in_range_s && (dst_s == 8'(i));
      end
    end
    if (({1'b0, g_r} + 9'd1) >= num_drv) begin
      next_ptr_s = 8'd0;
    end else begin
      next_ptr_s = g_r + 8'd1;
    end
  end

  // Next-state and next-output logic of the transaction sequencer.
  always_comb begin
    state_s  = state_r;
    ptr_s    = ptr_r;
    g_s      = g_r;
    pkt_s    = pkt_r;
    pop_s    = '0;
    push_s   = '0;
    d_push_s = d_push_r;
    drop_s   = drop_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          g_s = grant_s;
          for (int i = 0; i < drvrs; i++) begin
            pop_s[i] = (grant_s == 8'(i));
          end
          state_s = POP;
        end else begin
          state_s = IDLE;
        end
      end
      POP: begin
        pkt_s   = head_s;
        state_s = ROUTE;
      end
      ROUTE: begin
        if (!(is_bcast_s || in_range_s)) begin
          if (drop_r != 16'hFFFF) begin
            drop_s = drop_r + 16'd1;
          end else begin
            drop_s = drop_r;
          end
          ptr_s   = next_ptr_s;
          state_s = IDLE;
        end else if (mask_s == '0) begin
          ptr_s   = next_ptr_s;
          state_s = IDLE;
        end else if ((mask_s & full) != '0) begin
          state_s = ROUTE;
        end else begin
          push_s = mask_s;
          for (int i = 0; i < drvrs; i++) begin
            d_push_s[i*bits +: bits] = pkt_r;
          end
          ptr_s   = next_ptr_s;
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      ptr_r    <= 8'd0;
      g_r      <= 8'd0;
      pkt_r    <= '0;
      pop_r    <= '0;
      push_r   <= '0;
      d_push_r <= '0;
      drop_r   <= 16'd0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      ptr_r    <= ptr_s;
      g_r      <= g_s;
      pkt_r    <= pkt_s;
      pop_r    <= pop_s;
      push_r   <= push_s;
      d_push_r <= d_push_s;
      drop_r   <= drop_s;
      busy_r   <= (state_s != IDLE);
    end
  end

  assign pop      = pop_r;
  assign push     = push_r;
  assign D_push   = d_push_r;
  assign busy     = busy_r;
  assign drop_cnt = drop_r;

endmodule

// File: tb/tb_prll_bs_rbtr_n_drvrs.sv
// Testbench for prll_bs_rbtr_n_drvrs with drvrs=4, bits=32, broadcast=8'hFF.
module tb_prll_bs_rbtr_n_drvrs;
  localparam int ND = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   pndng;
  logic [3:0]   full;
  logic [127:0] d_pop;
  logic [3:0]   pop;
  logic [3:0]   push;
  logic [127:0] d_push;
  logic         busy;
  logic [15:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int m_ptr = 0;
  int m_drop = 0;

  prll_bs_rbtr_n_drvrs #(.bits(32), .drvrs(4), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .full(full), .D_pop(d_pop),
    .pop(pop), .push(push), .D_push(d_push), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First pending driver at or after ptr, wrapping modulo ND.
  function automatic int model_grant(int ptr, logic [3:0] pend);
    int idx;
    for (int k = 0; k < ND; k++) begin
      idx = (ptr + k) % ND;
      if (pend[idx]) return idx;
    end
    return -1;
  endfunction

  // Target set: broadcast = everyone but the source, in-range = that driver, else none.
  function automatic logic [3:0] model_mask(logic [7:0] dst, int g);
    if (dst == 8'hFF) return 4'b1111 & ~(4'b0001 << g);
    if (dst < 8'(ND)) return 4'b0001 << dst;
    return 4'b0000;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    pndng = 4'b1111;
    full  = 4'b1111;
    d_pop = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        reset = 1'b0;
        pndng = 4'b0000;
        full  = 4'b0000;
      end
      tick();
      n_cmp++; if (pop !== 4'b0000) begin n_err++; $display("FAIL reset_pop c=%0d: got %b want 0000", c, pop); end
      n_cmp++; if (push !== 4'b0000) begin n_err++; $display("FAIL reset_push c=%0d: got %b want 0000", c, push); end
      n_cmp++; if (d_push !== 128'd0) begin n_err++; $display("FAIL reset_dpush c=%0d: got %h want 0", c, d_push); end
      n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop c=%0d: got %0d want 0", c, drop_cnt); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy c=%0d: got %b want 0", c, busy); end
    end
    m_ptr = 0;
    m_drop = 0;
  endtask

  task automatic test_unicast();
    int g;
    logic [3:0] mask;
    tick();
    pndng = 4'b0001;
    d_pop = {$urandom, $urandom, $urandom, 32'h020000AB};
    g = model_grant(m_ptr, pndng);
    mask = model_mask(8'h02, g);
    tick();
    pndng = 4'b0000;
    n_cmp++; if (pop !== (4'b0001 << g)) begin n_err++; $display("FAIL uni_pop: got %b want %b", pop, 4'b0001 << g); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL uni_busy1: got %b want 1", busy); end
    tick();
    n_cmp++; if (push !== 4'b0000) begin n_err++; $display("FAIL uni_early_push: got %b want 0000", push); end
    tick();
    n_cmp++; if (push !== mask) begin n_err++; $display("FAIL uni_push: got %b want %b", push, mask); end
    n_cmp++; if (d_push[2*32 +: 32] !== 32'h020000AB) begin n_err++; $display("FAIL uni_data: got %h want 020000ab", d_push[2*32 +: 32]); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL uni_busy3: got %b want 0", busy); end
    m_ptr = (g + 1) % ND;
  endtask

  task automatic test_broadcast();
    int g;
    logic [3:0] mask;
    tick();
    pndng = 4'b0010;
    d_pop = {$urandom, $urandom, 32'hFF0000CD, $urandom};
    g = model_grant(m_ptr, pndng);
    mask = model_mask(8'hFF, g);
    tick();
    pndng = 4'b0000;
    n_cmp++; if (pop !== (4'b0001 << g)) begin n_err++; $display("FAIL bc_pop: got %b want %b", pop, 4'b0001 << g); end
    tick();
    tick();
    n_cmp++; if (push !== mask) begin n_err++; $display("FAIL bc_push: got %b want %b", push, mask); end
    for (int i = 0; i < ND; i++) begin
      if (mask[i]) begin
        n_cmp++; if (d_push[i*32 +: 32] !== 32'hFF0000CD) begin n_err++; $display("FAIL bc_data slice%0d: got %h want ff0000cd", i, d_push[i*32 +: 32]); end
      end
    end
    m_ptr = (g + 1) % ND;
  endtask

  task automatic test_round_robin();
    int order [5];
    logic [3:0] exp_pop;
    logic [3:0] exp_push;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_ptr = 0;
    m_drop = 0;
    for (int i = 0; i < ND; i++) d_pop[i*32 +: 32] = {8'h00, 24'($urandom)};
    pndng = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      order[n] = model_grant(m_ptr, 4'b1111);
      m_ptr = (order[n] + 1) % ND;
    end
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 14) pndng = 4'b0000;
      exp_pop  = (c % 3 == 1) ? (4'b0001 << order[(c - 1) / 3]) : 4'b0000;
      exp_push = (c % 3 == 0) ? 4'b0001 : 4'b0000;
      n_cmp++; if (pop !== exp_pop) begin n_err++; $display("FAIL rr_pop c=%0d: got %b want %b", c, pop, exp_pop); end
      n_cmp++; if (push !== exp_push) begin n_err++; $display("FAIL rr_push c=%0d: got %b want %b", c, push, exp_push); end
      n_cmp++; if (busy !== (c % 3 != 0)) begin n_err++; $display("FAIL rr_busy c=%0d: got %b want %b", c, busy, c % 3 != 0); end
      if (c % 3 == 0) begin
        n_cmp++;
        if (d_push[31:0] !== d_pop[order[c / 3 - 1]*32 +: 32]) begin
          n_err++; $display("FAIL rr_data c=%0d: got %h want %h", c, d_push[31:0], d_pop[order[c / 3 - 1]*32 +: 32]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int g;
    logic [31:0] pkt;
    tick();
    pndng = 4'b0001;
    full  = 4'b0000;
    pkt   = {8'h02, 24'($urandom)};
    d_pop = {$urandom, $urandom, $urandom, pkt};
    g = model_grant(m_ptr, pndng);
    tick();
    pndng = 4'b0000;
    n_cmp++; if (pop !== (4'b0001 << g)) begin n_err++; $display("FAIL bp_pop: got %b want %b", pop, 4'b0001 << g); end
    for (int c = 2; c <= 7; c++) begin
      tick();
      if (c == 2) begin
        full  = 4'b0100 | (4'($urandom) & 4'b1011);
        d_pop = {$urandom, $urandom, $urandom, $urandom};
      end
      if (c == 7) full = 4'($urandom) & 4'b1011;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy t+%0d: got %b want 1", c, busy); end
      n_cmp++; if (push !== 4'b0000) begin n_err++; $display("FAIL bp_stall_push t+%0d: got %b want 0000", c, push); end
    end
    tick();
    full = 4'b0000;
    n_cmp++; if (push !== 4'b0100) begin n_err++; $display("FAIL bp_push: got %b want 0100", push); end
    n_cmp++; if (d_push[2*32 +: 32] !== pkt) begin n_err++; $display("FAIL bp_data: got %h want %h", d_push[2*32 +: 32], pkt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy_end: got %b want 0", busy); end
    m_ptr = (g + 1) % ND;
  endtask

  task automatic test_invalid_reset();
    int g;
    tick();
    pndng = 4'b1000;
    d_pop = {32'h07000001, $urandom, $urandom, $urandom};
    g = model_grant(m_ptr, pndng);
    tick();
    pndng = 4'b0000;
    n_cmp++; if (pop !== (4'b0001 << g)) begin n_err++; $display("FAIL inv_pop: got %b want %b", pop, 4'b0001 << g); end
    tick();
    tick();
    m_drop++;
    m_ptr = (g + 1) % ND;
    n_cmp++; if (push !== 4'b0000) begin n_err++; $display("FAIL inv_push: got %b want 0000", push); end
    n_cmp++; if (drop_cnt !== 16'(m_drop)) begin n_err++; $display("FAIL inv_drop: got %0d want %0d", drop_cnt, m_drop); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL inv_busy: got %b want 0", busy); end
    pndng = 4'b1111;
    d_pop = {$urandom, $urandom, $urandom, 8'h01, 24'($urandom)};
    g = model_grant(m_ptr, pndng);
    tick();
    pndng = 4'b0000;
    n_cmp++; if (pop !== (4'b0001 << g)) begin n_err++; $display("FAIL inv_next_pop: got %b want %b", pop, 4'b0001 << g); end
    tick();
    reset = 1'b1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_route_busy: got %b want 1", busy); end
    tick();
    reset = 1'b0;
    n_cmp++; if (push !== 4'b0000) begin n_err++; $display("FAIL rst_push: got %b want 0000", push); end
    n_cmp++; if (pop !== 4'b0000) begin n_err++; $display("FAIL rst_pop: got %b want 0000", pop); end
    n_cmp++; if (d_push !== 128'd0) begin n_err++; $display("FAIL rst_dpush: got %h want 0", d_push); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    m_ptr = 0;
    m_drop = 0;
  endtask

  task automatic test_random();
    int g;
    int k;
    bit done;
    bit valid;
    logic [7:0] dst;
    logic [31:0] pkt;
    logic [3:0] mask;
    logic [3:0] fv;
    for (int n = 0; n < 40; n++) begin
      tick();
      pndng = 4'($urandom_range(1, 15));
      full  = 4'($urandom);
      for (int i = 0; i < ND; i++) begin
        case ($urandom_range(0, 5))
          0: dst = 8'hFF;
          1: dst = 8'($urandom_range(4, 254));
          default: dst = 8'($urandom_range(0, 3));
        endcase
        d_pop[i*32 +: 32] = {dst, 24'($urandom)};
      end
      g = model_grant(m_ptr, pndng);
      pkt = d_pop[g*32 +: 32];
      mask = model_mask(pkt[31:24], g);
      valid = (pkt[31:24] == 8'hFF) || (pkt[31:24] < 8'(ND));
      tick();
      pndng = 4'($urandom);
      n_cmp++; if (pop !== (4'b0001 << g)) begin n_err++; $display("FAIL rnd_pop n=%0d: got %b want %b", n, pop, 4'b0001 << g); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rnd_busy_pop n=%0d: got %b want 1", n, busy); end
      k = 0;
      done = 1'b0;
      while (!done) begin
        tick();
        pndng = 4'b0000;
        d_pop = {$urandom, $urandom, $urandom, $urandom};
        fv = (k >= 5) ? 4'b0000 : 4'($urandom);
        full = fv;
        n_cmp++; if (push !== 4'b0000 || busy !== 1'b1 || pop !== 4'b0000) begin
          n_err++; $display("FAIL rnd_route n=%0d k=%0d: got push=%b busy=%b pop=%b want 0000/1/0000", n, k, push, busy, pop);
        end
        if (!valid || ((mask & fv) == 4'b0000)) done = 1'b1;
        k++;
      end
      tick();
      full = 4'b0000;
      if (!valid && m_drop < 65535) m_drop++;
      n_cmp++; if (push !== mask) begin n_err++; $display("FAIL rnd_push n=%0d: got %b want %b", n, push, mask); end
      for (int i = 0; i < ND; i++) begin
        if (mask[i]) begin
          n_cmp++; if (d_push[i*32 +: 32] !== pkt) begin n_err++; $display("FAIL rnd_data n=%0d slice%0d: got %h want %h", n, i, d_push[i*32 +: 32], pkt); end
        end
      end
      n_cmp++; if (drop_cnt !== 16'(m_drop)) begin n_err++; $display("FAIL rnd_drop n=%0d: got %0d want %0d", n, drop_cnt, m_drop); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_busy_end n=%0d: got %b want 0", n, busy); end
      m_ptr = (g + 1) % ND;
    end
  endtask

  initial begin
    reset = 1'b1;
    pndng = 4'b0000;
    full  = 4'b0000;
    d_pop = 128'd0;
    test_reset();
    test_unicast();
    test_broadcast();
    test_round_robin();
    test_backpressure();
    test_invalid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
